// File: rtl/sim_pkg.sv
// Shared types and default grid geometry for the simulation sweep logic.
package sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

  localparam int GRID_X_BITS = 8;
  localparam int GRID_Y_BITS = 7;
  localparam int GRID_X_MAX  = 159;
  localparam int GRID_Y_MAX  = 119;
  localparam int MAX_LANES   = 8;

endpackage

// File: rtl/sweep_sequencer_if.sv
// Write-location bus from the sweep sequencer to the environment, env cache and ant array.
interface sweep_sequencer_if #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 7,
  parameter int LANES  = 1
);

  logic [LANES*X_BITS-1:0] sweep_x_o;
  logic [Y_BITS-1:0]       sweep_y_o;
  logic                    write_flag_o;
  logic                    hold_locs_o;

  modport master (
    output sweep_x_o,
    output sweep_y_o,
    output write_flag_o,
    output hold_locs_o
  );

  modport slave (
    input sweep_x_o,
    input sweep_y_o,
    input write_flag_o,
    input hold_locs_o
  );

endinterface

// File: rtl/sweep_sequencer_tick_divider.sv
// Game-tick enable generator: one-cycle pulse every max(factor,1) clocks.
module tick_divider #(
  parameter int TICK_W = 26
) (
  input  logic              clk,
  input  logic              RESET_SIM,
  input  logic [TICK_W-1:0] factor,
  output logic              tick
);

  logic [TICK_W-1:0] cnt;
  logic [TICK_W-1:0] last;
  logic [TICK_W-1:0] cnt_nxt;

  // A count left above the new terminal value after a factor change wraps without a tick.
  always_comb begin
    last    = (factor == '0) ? '0 : factor - 1'b1;
    cnt_nxt = (cnt >= last) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RESET_SIM) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == last);
    end
  end

endmodule

// File: rtl/sweep_sequencer.sv
// Raster-sweeps the environment grid once per permitted game tick, LANES cells per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | simulation disabled, locations held
//   ST_WAIT  | enabled, waiting for a tick that may start a frame
//   ST_SWEEP | issuing write locations, frame is atomic
//   ST_DONE  | one-cycle frame completion, frame counter bumps
module sweep_sequencer
  import sim_pkg::*;
#(
  parameter int X_BITS = GRID_X_BITS,
  parameter int Y_BITS = GRID_Y_BITS,
  parameter int X_MAX  = GRID_X_MAX,
  parameter int Y_MAX  = GRID_Y_MAX,
  parameter int LANES  = 1,
  parameter int TICK_W = 26
) (
  input  logic              clk,
  input  logic              RESET_SIM,
  input  logic              run_i,
  input  logic              pause_i,
  input  logic              step_i,
  input  logic [TICK_W-1:0] tick_factor_i,
  sweep_sequencer_if.master env,
  output logic              game_tick_o,
  output logic              frame_done_o,
  output logic [15:0]       frame_count_o,
  output logic              overrun_o,
  output logic [1:0]        state_o
);

  if (LANES < 1 || LANES > MAX_LANES || ((X_MAX + 1) % LANES) != 0) begin : g_bad_cfg
    $error("sweep_sequencer: LANES must be 1..8 and divide X_MAX+1");
  end

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_MAX + 1 - LANES);
  localparam logic [X_BITS-1:0] X_STEP = X_BITS'(LANES);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_MAX);

  sweep_state_t      state;
  logic [X_BITS-1:0] base_x;
  logic [15:0]       frame_cnt;
  logic              step_pend;
  logic              tick;

  tick_divider #(.TICK_W(TICK_W)) u_div (
    .clk       (clk),
    .RESET_SIM (RESET_SIM),
    .factor    (tick_factor_i),
    .tick      (tick)
  );

  function automatic logic [LANES*X_BITS-1:0] lanes_at(input logic [X_BITS-1:0] b);
    logic [LANES*X_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*X_BITS +: X_BITS] = b + X_BITS'(k);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (RESET_SIM) begin
      state            <= ST_IDLE;
      base_x           <= '0;
      env.sweep_x_o    <= '0;
      env.sweep_y_o    <= '0;
      env.write_flag_o <= 1'b0;
      env.hold_locs_o  <= 1'b1;
      frame_done_o     <= 1'b0;
      frame_cnt        <= '0;
      overrun_o        <= 1'b0;
      step_pend        <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (step_i) step_pend <= 1'b1;
      case (state)
        ST_IDLE: if (run_i) state <= ST_WAIT;
        ST_WAIT: begin
          if (!run_i) begin
            state <= ST_IDLE;
          end else if (tick && (!pause_i || step_pend || step_i)) begin
            // a step arriving with this tick is consumed by this frame
            state            <= ST_SWEEP;
            step_pend        <= 1'b0;
            base_x           <= '0;
            env.sweep_x_o    <= lanes_at('0);
            env.sweep_y_o    <= '0;
            env.write_flag_o <= 1'b1;
            env.hold_locs_o  <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (tick) overrun_o <= 1'b1;
          if (base_x == X_LAST) begin
            base_x <= '0;
            if (env.sweep_y_o == Y_LAST) begin
              state            <= ST_DONE;
              env.sweep_x_o    <= '0;
              env.sweep_y_o    <= '0;
              env.write_flag_o <= 1'b0;
              env.hold_locs_o  <= 1'b1;
              frame_done_o     <= 1'b1;
              frame_cnt        <= frame_cnt + 16'd1;
            end else begin
              env.sweep_x_o <= lanes_at('0);
              env.sweep_y_o <= env.sweep_y_o + 1'b1;
            end
          end else begin
            base_x        <= base_x + X_STEP;
            env.sweep_x_o <= lanes_at(base_x + X_STEP);
          end
        end
        ST_DONE: state <= run_i ? ST_WAIT : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game_tick_o   = tick;
  assign frame_count_o = frame_cnt;
  assign state_o       = state;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: a 1-lane 4x2 grid and a 4-lane 8x2 grid driven side by side.
module tb_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, pause, step;
  logic [25:0] factor;

  always #5 clk = ~clk;

  sweep_sequencer_if #(.X_BITS(8), .Y_BITS(7), .LANES(1)) bus1 ();
  sweep_sequencer_if #(.X_BITS(8), .Y_BITS(7), .LANES(4)) bus4 ();

  logic        tick1, done1, ovr1, tick4, done4, ovr4;
  logic [15:0] cnt1, cnt4;
  logic [1:0]  st1, st4;

  sweep_sequencer #(.X_BITS(8), .Y_BITS(7), .X_MAX(3), .Y_MAX(1), .LANES(1), .TICK_W(26)) dut1 (
    .clk(clk), .RESET_SIM(rst), .run_i(run), .pause_i(pause), .step_i(step),
    .tick_factor_i(factor), .env(bus1), .game_tick_o(tick1), .frame_done_o(done1),
    .frame_count_o(cnt1), .overrun_o(ovr1), .state_o(st1));

  sweep_sequencer #(.X_BITS(8), .Y_BITS(7), .X_MAX(7), .Y_MAX(1), .LANES(4), .TICK_W(26)) dut4 (
    .clk(clk), .RESET_SIM(rst), .run_i(run), .pause_i(pause), .step_i(step),
    .tick_factor_i(factor), .env(bus4), .game_tick_o(tick4), .frame_done_o(done4),
    .frame_count_o(cnt4), .overrun_o(ovr4), .state_o(st4));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame progress kept as a linear cell index, coordinates derived arithmetically.
  int xm [2] = '{3, 7};
  int ym [2] = '{1, 1};
  int ln [2] = '{1, 4};
  int m_cnt;
  bit m_tick;
  int m_mode [2];
  int m_cell [2];
  int m_count[2];
  bit m_over [2];
  bit m_pend [2];

  task automatic model_step();
    int f;
    bit t;
    f = (factor == 0) ? 1 : int'(factor);
    t = m_tick;
    if (rst) begin
      m_cnt  = 0;
      m_tick = 0;
      for (int d = 0; d < 2; d++) begin
        m_mode[d] = 0; m_cell[d] = 0; m_count[d] = 0; m_over[d] = 0; m_pend[d] = 0;
      end
    end else begin
      m_cnt  = (m_cnt >= f - 1) ? 0 : m_cnt + 1;
      m_tick = (m_cnt == f - 1);
      for (int d = 0; d < 2; d++) begin
        int flen;
        bit pend_in;
        flen    = (xm[d] + 1) * (ym[d] + 1) / ln[d];
        pend_in = m_pend[d];
        if (step) m_pend[d] = 1;
        case (m_mode[d])
          0: if (run) m_mode[d] = 1;
          1: begin
            if (!run) m_mode[d] = 0;
            else if (t && (!pause || pend_in || step)) begin
              m_mode[d] = 2; m_cell[d] = 0; m_pend[d] = 0;
            end
          end
          2: begin
            if (t) m_over[d] = 1;
            if (m_cell[d] == flen - 1) begin
              m_mode[d]  = 3;
              m_count[d] = (m_count[d] + 1) % 65536;
            end else m_cell[d]++;
          end
          default: m_mode[d] = run ? 1 : 0;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] ex;
      int bx, ey;
      bit wf;
      wf = (m_mode[d] == 2);
      ex = '0; ey = 0; bx = 0;
      if (wf) begin
        bx = (m_cell[d] * ln[d]) % (xm[d] + 1);
        ey = (m_cell[d] * ln[d]) / (xm[d] + 1);
        for (int k = 0; k < ln[d]; k++) ex[k*8 +: 8] = 8'(bx + k);
      end
      check($sformatf("d%0d state", d), 32'(d == 0 ? st1 : st4), 32'(m_mode[d]));
      check($sformatf("d%0d write_flag", d), 32'(d == 0 ? bus1.write_flag_o : bus4.write_flag_o), 32'(wf));
      check($sformatf("d%0d hold_locs", d), 32'(d == 0 ? bus1.hold_locs_o : bus4.hold_locs_o), 32'(!wf));
      check($sformatf("d%0d sweep_x", d), d == 0 ? {24'b0, bus1.sweep_x_o} : bus4.sweep_x_o, ex);
      check($sformatf("d%0d sweep_y", d), 32'(d == 0 ? bus1.sweep_y_o : bus4.sweep_y_o), 32'(ey));
      check($sformatf("d%0d frame_done", d), 32'(d == 0 ? done1 : done4), 32'(m_mode[d] == 3));
      check($sformatf("d%0d frame_count", d), 32'(d == 0 ? cnt1 : cnt4), 32'(m_count[d]));
      check($sformatf("d%0d overrun", d), 32'(d == 0 ? ovr1 : ovr4), 32'(m_over[d]));
      check($sformatf("d%0d game_tick", d), 32'(d == 0 ? tick1 : tick4), 32'(m_tick));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_wf(input int bound, output bit found);
    found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      cycle();
      if (bus1.write_flag_o) found = 1;
    end
  endtask

  task automatic wait_done(input int bound, output bit found);
    found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      cycle();
      if (done1) found = 1;
    end
  endtask

  typedef struct {
    bit rst, run;
    int st, wf, x, y, done, cnt, tick, ovr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    bit found;
    int n;

    // factor 3 on the 4x2 grid: ticks every 3 cycles, frame of 8 overruns
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{0, 1, 2, 1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 2, 1, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 2, 1, 2, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 1, 2, 1, 3, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 2, 1, 0, 1, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 2, 1, 1, 1, 0, 0, 1, 1};
    tbl[9]  = '{0, 1, 2, 1, 2, 1, 0, 0, 0, 1};
    tbl[10] = '{0, 1, 2, 1, 3, 1, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 3, 0, 0, 0, 1, 1, 1, 1};
    tbl[12] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 1};
    tbl[13] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 1};
    tbl[14] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    tbl[15] = '{0, 1, 2, 1, 0, 0, 0, 1, 0, 1};

    rst = 1'b1; run = 1'b0; pause = 1'b0; step = 1'b0; factor = 26'd3;
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst;
      run = tbl[i].run;
      cycle();
      check($sformatf("tbl%0d state", i), 32'(st1), tbl[i].st);
      check($sformatf("tbl%0d write_flag", i), 32'(bus1.write_flag_o), tbl[i].wf);
      check($sformatf("tbl%0d hold_locs", i), 32'(bus1.hold_locs_o), 32'(tbl[i].wf == 0));
      check($sformatf("tbl%0d x", i), 32'(bus1.sweep_x_o), tbl[i].x);
      check($sformatf("tbl%0d y", i), 32'(bus1.sweep_y_o), tbl[i].y);
      check($sformatf("tbl%0d done", i), 32'(done1), tbl[i].done);
      check($sformatf("tbl%0d count", i), 32'(cnt1), tbl[i].cnt);
      check($sformatf("tbl%0d tick", i), 32'(tick1), tbl[i].tick);
      check($sformatf("tbl%0d overrun", i), 32'(ovr1), tbl[i].ovr);
    end

    // pause blocks frames; a step yields exactly one; releasing pause resumes
    factor = 26'd12; pause = 1'b1; run = 1'b1;
    do_reset();
    n = 0;
    repeat (60) begin cycle(); if (bus1.write_flag_o) n++; end
    check("paused wf cycles", 32'(n), 32'd0);
    step = 1'b1; cycle(); step = 1'b0;
    n = 0;
    repeat (36) begin cycle(); if (done1) n++; end
    check("step frame count", 32'(n), 32'd1);
    check("step frames d1", 32'(cnt1), 32'd1);
    pause = 1'b0;
    wait_wf(13, found);
    check("resume after unpause", 32'(found), 32'd1);

    // overrun: factor 5 is too short for the 8-cell frame, just enough for the 4-cell one
    factor = 26'd5;
    do_reset();
    wait_done(30, found);
    check("overrun first frame done", 32'(found), 32'd1);
    check("overrun set in first frame", 32'(ovr1), 32'd1);
    n = 0;
    repeat (40) begin cycle(); if (!ovr1) n++; end
    check("overrun sticky", 32'(n), 32'd0);
    check("no overrun at F=frame+1", 32'(ovr4), 32'd0);

    // reset at the third SWEEP cycle aborts the frame
    factor = 26'd12;
    do_reset();
    wait_wf(20, found);
    check("pre-reset sweep started", 32'(found), 32'd1);
    cycle(); cycle();
    check("third sweep cycle x", 32'(bus1.sweep_x_o), 32'd2);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("mid reset state", 32'(st1), 32'd0);
    check("mid reset write_flag", 32'(bus1.write_flag_o), 32'd0);
    check("mid reset hold_locs", 32'(bus1.hold_locs_o), 32'd1);
    check("mid reset frame_count", 32'(cnt1), 32'd0);
    check("mid reset frame_done", 32'(done1), 32'd0);
    wait_wf(20, found);
    check("restart sweep found", 32'(found), 32'd1);
    check("restart x", 32'(bus1.sweep_x_o), 32'd0);
    check("restart y", 32'(bus1.sweep_y_o), 32'd0);
    check("restart x4", bus4.sweep_x_o, 32'h03020100);

    // factor 0 behaves as 1: a tick every cycle
    factor = 26'd0;
    repeat (10) begin cycle(); check("factor0 tick", 32'(tick1), 32'd1); end

    // frame counter wrap from a preloaded 0xFFFE
    factor = 26'd12;
    do_reset();
    cycle();
    force dut1.frame_cnt = 16'hFFFE;
    force dut4.frame_cnt = 16'hFFFE;
    #1;
    release dut1.frame_cnt;
    release dut4.frame_cnt;
    m_count[0] = 65534;
    m_count[1] = 65534;
    wait_done(40, found);
    check("wrap first done", 32'(found), 32'd1);
    check("count 0xFFFF", 32'(cnt1), 32'hFFFF);
    wait_done(40, found);
    check("wrap second done", 32'(found), 32'd1);
    check("count wraps to 0", 32'(cnt1), 32'd0);

    // dropping run mid-frame finishes the frame, then idles
    wait_wf(20, found);
    check("run-drop sweep found", 32'(found), 32'd1);
    cycle();
    run = 1'b0;
    wait_done(20, found);
    check("run-drop frame completes", 32'(found), 32'd1);
    cycle();
    check("run-drop idle", 32'(st1), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      run   = ($urandom_range(0, 15) != 0);
      pause = ($urandom_range(0, 3) == 0);
      step  = ($urandom_range(0, 19) == 0);
      if (i % 100 == 0) factor = 26'($urandom_range(0, 14));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

Parametrised successor to the simulation's location stepping and sim-state control. It divides the system clock into game ticks and, on each permitted tick, raster-sweeps the environment grid exactly once. Each cycle it presents `LANES` adjacent write locations with a write strobe. It adds run/pause/single-step modes, atomic frames, a frame counter and overrun detection, and drives `writeLoc_x/y`, `write_flag` and `hold_locs` for the environment, env cache and ant array.

## Interface
- `X_BITS`, 8: width of the X coordinate.
- `Y_BITS`, 7: width of the Y coordinate.
- `X_MAX`, 159: last X index. `(X_MAX+1) % LANES == 0` is required.
- `Y_MAX`, 119: last Y index.
- `LANES`, 1: cells issued per cycle, 1..8.
- `TICK_W`, 26: width of the tick divider.
- `clk`, in, 1: system clock (CLOCK_50). The block has one clock.
- `RESET_SIM`, in, 1: reset. Synchronous, active-high.
- `run_i`, in, 1: simulation enabled. Low means the block goes idle once any frame in progress completes.
- `pause_i`, in, 1: level. Blocks new frames.
- `step_i`, in, 1: pulse. Requests one frame while paused.
- `tick_factor_i`, in, TICK_W: clocks per game tick. A value of 0 is treated as 1.
- `sweep_x_o`, out, LANES×X_BITS: X of each lane. Lane k equals `base_x + k`.
- `sweep_y_o`, out, Y_BITS: row shared by all lanes.
- `write_flag_o`, out, 1: current locations are valid and are to be written.
- `hold_locs_o`, out, 1: high whenever no sweep is in progress. This is exactly `~write_flag_o`.
- `game_tick_o`, out, 1: one-cycle pulse per divider period.
- `frame_done_o`, out, 1: one-cycle pulse after the last cell of a frame is issued.
- `frame_count_o`, out, 16: number of completed frames. Wraps.
- `overrun_o`, out, 1: sticky. Set when a tick arrives during SWEEP.
- `state_o`, out, 2: encoded FSM state, for debug LEDs.

## Operation
- **States:** IDLE=0, WAIT=1, SWEEP=2, DONE=3.
- **Divider:** `tick_cnt` counts 0..F-1, where `F = max(tick_factor_i,1)`. `game_tick_o` is high in the cycle `tick_cnt == F-1`, then the counter wraps to 0.
  - The divider runs in every state except reset.
  - If `tick_factor_i` changes so that `tick_cnt > F-1`, the counter wraps to 0 on the next cycle and no tick is issued for that cycle.
- **IDLE → WAIT:** when `run_i` is high.
- **WAIT → SWEEP:** on `game_tick_o` when `run_i` is high and either `pause_i` is low or `step_pend` is set.
  - `step_pend` is set by `step_i` in any state.
  - It is cleared on entry to SWEEP.
- **WAIT → IDLE:** when `run_i` is low.
- **SWEEP:** starts at base (0,0). Each cycle:
  - `base_x += LANES`.
  - When `base_x == X_MAX+1-LANES`, the next `base_x` is 0 and `sweep_y_o` increments.
  - The cycle at `base_x == X_MAX+1-LANES` with `y == Y_MAX` is the last cell. The next state is DONE.
- **Frame rules:**
  - `pause_i` and `run_i` are ignored mid-SWEEP. Frames are atomic.
  - A tick during SWEEP sets `overrun_o` and is discarded. It is not queued.
- **DONE** lasts one cycle:
  - `frame_done_o` is high.
  - `frame_count_o` increments. It wraps 0xFFFF → 0.
  - Coordinates return to 0.
  - Next state is WAIT if `run_i` is high, otherwise IDLE.
- **Coordinates outside SWEEP:** held at 0.
- **Reset values:** on `RESET_SIM`, all outputs are 0 except `hold_locs_o`, which is 1. State goes to IDLE. `tick_cnt`, `step_pend` and `overrun_o` are cleared.
  - Reset mid-SWEEP aborts the frame. `frame_done_o` is not pulsed and the frame count is unchanged.

## Timing
- All outputs are registered.
- The first SWEEP cycle, with base (0,0), is the cycle after the `game_tick_o` pulse.
- A frame lasts `(X_MAX+1)(Y_MAX+1)/LANES` SWEEP cycles, followed by 1 DONE cycle.
- `frame_done_o` is asserted in the cycle after the last `write_flag_o` cycle.
- `step_i` coincident with a tick while in WAIT and paused starts the frame on that same tick. The set and the use of `step_pend` happen in the same cycle.
- A minimum period of `F ≥ frame_length+1` is required to avoid overrun.

## Structure
- Shared package `sim_pkg`:
  - `sweep_state_t` enum.
  - Default grid constants (`X_bits`, `Y_bits`, `X_MAX`, `Y_MAX`).
  - Lane limit of 8.
- Sub-module `tick_divider`, which takes `clk`, `RESET_SIM` and `factor`, and produces `tick`. It replaces the gated clock produced by clock_cutter with an enable pulse.
- The FSM, coordinate counters and lane expansion live in `sweep_sequencer`.

## Test plan
- **Single-lane frame** (X_MAX=3, Y_MAX=1, LANES=1, factor=20, run=1, pause=0):
  - `write_flag_o` is high for exactly 8 cycles, visiting (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1).
  - `frame_done_o` pulses 1 cycle later and `frame_count_o` is 1.
  - The next frame starts 20 cycles after the previous tick.
- **Multi-lane** (X_MAX=7, Y_MAX=1, LANES=4):
  - Sweep lasts 4 cycles.
  - Lanes show {0,1,2,3} then {4,5,6,7}, once per row, for y = 0 then 1.
- **Pause/step:**
  - With `pause_i`=1, there are no sweeps for 5 ticks.
  - A single `step_i` pulse produces exactly 1 frame on the next tick, then none.
  - Deasserting pause after 2 more ticks resumes sweeps on the following tick.
- **Overrun** (factor=5, frame length 8):
  - `overrun_o` is set within the first frame and stays set.
  - Frames never overlap.
  - Each new frame starts on a tick that lands in WAIT.
- **Reset mid-frame:**
  - Assert `RESET_SIM` at the 3rd SWEEP cycle. On the next cycle `state_o`=0, `write_flag_o`=0, `hold_locs_o`=1 and `frame_count_o` is unchanged.
  - After release with run=1, the next frame starts again from (0,0).
- **Boundaries:**
  - `tick_factor_i`=0 produces a tick every cycle.
  - `frame_count_o` preloaded via 65535 frames (or forced) wraps to 0.
  - Dropping `run_i` mid-frame completes the frame, then the state goes to IDLE.
